normal_transform: RTL and testbench

NORMAL_TRANSFORM -- requirements
Module: normal_transform

---
 rtl/normal_transform.sv | 135 +++++++++++++
 tb/tb_normal_transform.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/normal_transform.sv
// rtl/normal_transform.sv - 3x3 matrix transform of vertex normals, one fixed-point MAC per cycle
package normal_transform_pkg;
    typedef logic signed [31:0] FixedPoint_t;

    typedef struct packed {
        FixedPoint_t x;
        FixedPoint_t y;
        FixedPoint_t z;
        FixedPoint_t w;
    } Vector4_t;

    localparam FixedPoint_t FP_ONE = 32'sh0001_0000;

    // Q16.16: full signed product, arithmetic shift right by 16, keep the low 32 bits (wraps)
    function automatic FixedPoint_t fixed_point_multiply(input FixedPoint_t a, input FixedPoint_t b);
        logic signed [63:0] p;
        p = a * b;
        return p[47:16];
    endfunction

    function automatic FixedPoint_t fixed_point_add(input FixedPoint_t a, input FixedPoint_t b);
        return a + b;
    endfunction
endpackage

module normal_transform
    import normal_transform_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  Vector4_t    i_normal,
    input  Vector4_t    i_colour,
    input  logic        i_matrix_we,
    input  logic [1:0]  i_matrix_row_index,
    input  Vector4_t    i_matrix_row,
    output logic        o_valid,
    input  logic        i_ready,
    output Vector4_t    o_normal,
    output Vector4_t    o_colour
);
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t      state, state_next;
    logic        live;
    logic [3:0]  term;
    logic [1:0]  row_sel, col_sel;
    logic        accept;
    FixedPoint_t matrix [3][3];
    FixedPoint_t work   [3][3];
    FixedPoint_t nrm    [3];
    FixedPoint_t acc    [3];
    FixedPoint_t product, mac_sum;
    Vector4_t    colour_q;

    // live holds o_ready low until the first edge with reset released
    assign o_ready = (state == IDLE) && live;
    assign o_valid = (state == DONE);
    assign accept  = i_valid && o_ready;

    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (term)
            4'd0: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7: begin row_sel = 2'd2; col_sel = 2'd1; end
            4'd8: begin row_sel = 2'd2; col_sel = 2'd2; end
            default: begin row_sel = 2'd0; col_sel = 2'd0; end
        endcase
    end

    assign product = fixed_point_multiply(work[row_sel][col_sel], nrm[col_sel]);
    assign mac_sum = fixed_point_add(acc[row_sel], product);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (term == 4'd8) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            live     <= 1'b0;
            term     <= 4'd0;
            o_normal <= '0;
            o_colour <= '0;
            colour_q <= '0;
            for (int r = 0; r < 3; r++) begin
                acc[r] <= '0;
                nrm[r] <= '0;
                for (int c = 0; c < 3; c++) begin
                    matrix[r][c] <= (r == c) ? FP_ONE : '0;
                    work[r][c]   <= '0;
                end
            end
        end else begin
            state <= state_next;
            live  <= 1'b1;
            // Nonblocking: an acceptance on the same edge snapshots the pre-write matrix
            if (i_matrix_we && i_matrix_row_index != 2'd3) begin
                matrix[i_matrix_row_index][0] <= i_matrix_row.x;
                matrix[i_matrix_row_index][1] <= i_matrix_row.y;
                matrix[i_matrix_row_index][2] <= i_matrix_row.z;
            end
            if (accept) begin
                work     <= matrix;
                nrm[0]   <= i_normal.x;
                nrm[1]   <= i_normal.y;
                nrm[2]   <= i_normal.z;
                colour_q <= i_colour;
                term     <= 4'd0;
                for (int r = 0; r < 3; r++) acc[r] <= '0;
            end else if (state == MAC) begin
                acc[row_sel] <= mac_sum;
                term         <= term + 4'd1;
                if (term == 4'd8) begin
                    o_normal <= {acc[0], acc[1], mac_sum, 32'sd0};
                    o_colour <= colour_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_normal_transform.sv
// tb/tb_normal_transform.sv - scoreboard bench for normal_transform
module tb_normal_transform;
    import normal_transform_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    Vector4_t    i_normal = '0;
    Vector4_t    i_colour = '0;
    logic        i_matrix_we = 1'b0;
    logic [1:0]  i_matrix_row_index = 2'd0;
    Vector4_t    i_matrix_row = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    Vector4_t    o_normal;
    Vector4_t    o_colour;

    typedef struct {
        Vector4_t n;
        Vector4_t c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    localparam FixedPoint_t ONE  = 32'sh0001_0000;
    localparam FixedPoint_t HALF = 32'sh0000_8000;
    localparam FixedPoint_t QTR  = 32'sh0000_4000;
    localparam FixedPoint_t TWO  = 32'sh0002_0000;
    localparam FixedPoint_t THR  = 32'sh0003_0000;
    localparam FixedPoint_t NEG1 = -32'sh0001_0000;
    localparam FixedPoint_t Z    = 32'sh0;

    normal_transform dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_normal(i_normal), .i_colour(i_colour), .i_matrix_we(i_matrix_we),
        .i_matrix_row_index(i_matrix_row_index), .i_matrix_row(i_matrix_row),
        .o_valid(o_valid), .i_ready(i_ready), .o_normal(o_normal), .o_colour(o_colour)
    );

    always #5 i_clk = ~i_clk;

    function automatic Vector4_t vec(input FixedPoint_t x, input FixedPoint_t y,
                                     input FixedPoint_t z, input FixedPoint_t w);
        return {x, y, z, w};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 256'(o_valid), 256'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_normal", 256'(o_normal), 256'(mon_e.n));
                check("sb_colour", 256'(o_colour), 256'(mon_e.c));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", {o_ready, o_valid, o_normal, o_colour}, 256'(0));
        i_reset_n = 1'b1;
        tick();
        check("ready_after_reset", 256'(o_ready), 256'(1));
    endtask

    task automatic write_row(input logic [1:0] idx, input Vector4_t row);
        i_matrix_we = 1'b1;
        i_matrix_row_index = idx;
        i_matrix_row = row;
        tick();
        i_matrix_we = 1'b0;
    endtask

    task automatic accept_vertex(input Vector4_t n, input Vector4_t c, input bit push,
                                 input Vector4_t exp_n, input bit we, input logic [1:0] idx,
                                 input Vector4_t row);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_ready", 256'(o_ready), 256'(1));
        i_valid = 1'b1;
        i_normal = n;
        i_colour = c;
        i_matrix_we = we;
        i_matrix_row_index = idx;
        i_matrix_row = row;
        tick();
        i_valid = 1'b0;
        i_matrix_we = 1'b0;
        // Inputs outside the acceptance edge must be ignored
        i_normal = vec(THR, THR, THR, THR);
        i_colour = vec(NEG1, NEG1, NEG1, NEG1);
        if (push) exp_q.push_back('{n: exp_n, c: c});
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!o_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", 256'(cyc), 256'(9));
    endtask

    task automatic run(input Vector4_t n, input Vector4_t c, input Vector4_t exp_n);
        accept_vertex(n, c, 1'b1, exp_n, 1'b0, 2'd0, '0);
        wait_valid();
        tick();
    endtask

    initial begin
        int guard;
        do_reset();

        // Row index 3 is ignored; identity remains
        write_row(2'd3, vec(THR, THR, THR, THR));
        run(vec(Z, ONE, Z, ONE), vec(ONE, HALF, Z, ONE), vec(Z, ONE, Z, Z));

        write_row(2'd0, vec(TWO, Z, Z, Z));
        write_row(2'd1, vec(Z, TWO, Z, Z));
        write_row(2'd2, vec(Z, Z, TWO, Z));
        run(vec(HALF, QTR, ONE, Z), vec(Z, Z, ONE, Z), vec(ONE, HALF, TWO, Z));

        write_row(2'd0, vec(Z, NEG1, Z, Z));
        write_row(2'd1, vec(ONE, Z, Z, Z));
        write_row(2'd2, vec(Z, Z, ONE, Z));
        run(vec(ONE, Z, Z, Z), vec(HALF, HALF, HALF, HALF), vec(Z, ONE, Z, Z));

        // Backpressure in DONE
        i_ready = 1'b0;
        accept_vertex(vec(Z, ONE, Z, Z), vec(QTR, Z, QTR, ONE), 1'b1, vec(NEG1, Z, Z, Z),
                      1'b0, 2'd0, '0);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_hold", {o_valid, o_ready, o_normal, o_colour},
                  {1'b1, 1'b0, vec(NEG1, Z, Z, Z), vec(QTR, Z, QTR, ONE)});
        end
        i_ready = 1'b1;
        tick();
        check("after_transfer", {o_valid, o_ready}, {1'b0, 1'b1});

        // Coincident matrix write and acceptance
        do_reset();
        accept_vertex(vec(ONE, Z, Z, Z), vec(ONE, ONE, Z, Z), 1'b1, vec(ONE, Z, Z, Z),
                      1'b1, 2'd0, vec(THR, Z, Z, Z));
        wait_valid();
        tick();
        run(vec(ONE, Z, Z, Z), vec(Z, ONE, ONE, Z), vec(THR, Z, Z, Z));

        // Reset at term 4 discards the vertex and restores identity
        accept_vertex(vec(Z, Z, ONE, Z), vec(ONE, ONE, ONE, ONE), 1'b0, '0, 1'b0, 2'd0, '0);
        for (int i = 0; i < 4; i++) tick();
        i_reset_n = 1'b0;
        tick();
        check("midmac_reset", {o_valid, o_ready, o_normal, o_colour}, 256'(0));
        i_reset_n = 1'b1;
        tick();
        check("midmac_ready", 256'(o_ready), 256'(1));
        guard = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_valid) guard++;
        end
        check("midmac_no_valid", 256'(guard), 256'(0));
        run(vec(HALF, QTR, ONE, ONE), vec(Z, Z, Z, ONE), vec(HALF, QTR, ONE, Z));

        // Truncation, wrap-around and negative products
        write_row(2'd0, vec(32'sh0001_8000, Z, Z, Z));
        write_row(2'd1, vec(Z, 32'sh7FFF_0000, 32'sh7FFF_0000, Z));
        write_row(2'd2, vec(Z, Z, -HALF, Z));
        run(vec(32'sh3, ONE, ONE, Z), vec(ONE, Z, Z, Z),
            vec(32'sh4, 32'shFFFE_0000, 32'shFFFF_8000, Z));

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
